// File: rtl/segled_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble) for seven-segment displays.
// Publishes the packed BCD result, a leading-zero blanking mask and an overflow flag.
module segled_bcd_converter #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]       MAX_VAL   = pow10(DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DATA_W - 1);
  localparam logic [BCD_W-1:0]  NINES     = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_cap_q, ovf_cap_d;
  logic               busy_d, done_d, ovf_d;
  logic [BCD_W-1:0]   bcd_out_d;
  logic [DIGITS-1:0]  blank_d;

  logic [BCD_W-1:0]   adj;
  logic [SR_W-1:0]    sh;
  logic [BCD_W-1:0]   res;
  logic [DIGITS-1:0]  blk;
  logic               zero_run;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      blank     <= BLANK_RST;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      busy      <= busy_d;
      done      <= done_d;
      bcd_out   <= bcd_out_d;
      blank     <= blank_d;
      ovf       <= ovf_d;
    end
  end

  // Next-state, double-dabble step and result formatting
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    ovf_cap_d = ovf_cap_q;
    busy_d    = busy;
    done_d    = 1'b0;
    bcd_out_d = bcd_out;
    blank_d   = blank;
    ovf_d     = ovf;

    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh = {adj, bin_q} << 1;

    // Overflowed inputs saturate to all nines; the shifted value is meaningless then
    res = ovf_cap_q ? NINES : bcd_q;
    zero_run = 1'b1;
    blk      = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run = zero_run && (res[4*i +: 4] == 4'd0);
      blk[i]   = zero_run;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          bcd_d     = '0;
          cnt_d     = '0;
          ovf_cap_d = 64'(bin_in) > MAX_VAL;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = sh[SR_W-1:DATA_W];
        bin_d = sh[DATA_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        bcd_out_d = res;
        blank_d   = ovf_cap_q ? '0 : blk;
        ovf_d     = ovf_cap_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_segled_bcd_converter.sv
// Self-checking bench for segled_bcd_converter: vector table plus scoreboard
// checked on every done pulse, with hand-written multi-cycle corner cases.
module tb_segled_bcd_converter;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned DIGITS = 6;
  localparam int          LAT    = 21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic [5:0]  blank;
  logic        ovf;

  typedef struct {
    logic [23:0] bcd;
    logic [5:0]  blank;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [5:0]  blank;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  segled_bcd_converter #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start),
    .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference model
  function automatic exp_t model(input int unsigned v);
    exp_t e;
    int unsigned x;
    logic z;
    e.ovf = (v > 999999);
    e.bcd = '0;
    e.blank = '0;
    e.cyc = 0;
    if (e.ovf) begin
      e.bcd = 24'h999999;
    end else begin
      x = v;
      for (int d = 0; d < 6; d++) begin
        e.bcd[4*d +: 4] = 4'(x % 10);
        x = x / 10;
      end
      z = 1'b1;
      for (int i = 5; i >= 1; i--) begin
        z = z & (e.bcd[4*i +: 4] == 4'd0);
        e.blank[i] = z;
      end
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(e.bcd));
        check("blank", 64'(blank), 64'(e.blank));
        check("ovf", 64'(ovf), 64'(e.ovf));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_at_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic push_exp(input logic [23:0] b, input logic [5:0] bl, input logic o, input int at);
    exp_t e;
    e.bcd = b; e.blank = bl; e.ovf = o; e.cyc = at;
    sb.push_back(e);
  endtask

  // One conversion; bin_in is scrambled after capture
  task automatic run(input logic [19:0] v, input logic [23:0] b, input logic [5:0] bl, input logic o);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    push_exp(b, bl, o, cyc + 1 + LAT);
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    check("busy_high", 64'(busy), 64'(1));
    repeat (LAT) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int budget;
    budget = 1000;
    while (cyc < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (cyc != target) check("wait_cyc", 64'(cyc), 64'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_bcd"}, 64'(bcd_out), 64'(0));
    check({tag, "_blank"}, 64'(blank), 64'(6'b111110));
    check({tag, "_ovf"}, 64'(ovf), 64'(0));
  endtask

  initial begin
    vec_t vecs[10];
    exp_t m;
    int   c;
    logic [19:0] r;

    vecs[0] = '{20'd0,       24'h000000, 6'b111110, 1'b0};
    vecs[1] = '{20'd123456,  24'h123456, 6'b000000, 1'b0};
    vecs[2] = '{20'd907,     24'h000907, 6'b111000, 1'b0};
    vecs[3] = '{20'd999999,  24'h999999, 6'b000000, 1'b0};
    vecs[4] = '{20'd1000000, 24'h999999, 6'b000000, 1'b1};
    vecs[5] = '{20'hFFFFF,   24'h999999, 6'b000000, 1'b1};
    vecs[6] = '{20'd5,       24'h000005, 6'b111110, 1'b0};
    vecs[7] = '{20'd10,      24'h000010, 6'b111100, 1'b0};
    vecs[8] = '{20'd100000,  24'h100000, 6'b000000, 1'b0};
    vecs[9] = '{20'd80604,   24'h080604, 6'b100000, 1'b0};

    rst_n = 1'b0; start = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run(vecs[i].bin, vecs[i].bcd, vecs[i].blank, vecs[i].ovf);

    for (int i = 0; i < 6; i++) begin
      r = 20'($urandom_range(0, 20'hFFFFF));
      m = model(int'(r));
      run(r, m.bcd, m.blank, m.ovf);
    end

    // Second start while busy is ignored
    @(negedge clk);
    c = cyc;
    bin_in = 20'd42; start = 1'b1;
    push_exp(24'h000042, 6'b111100, 1'b0, c + 1 + LAT);
    @(negedge clk);
    start = 1'b0; bin_in = 20'd777;
    wait_cyc(c + 5);
    start = 1'b1; bin_in = 20'd100;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 1 + LAT);
    // Outputs hold after done despite input activity
    bin_in = 20'd31337;
    repeat (5) @(negedge clk);
    check("hold_bcd", 64'(bcd_out), 64'(24'h000042));
    check("hold_blank", 64'(blank), 64'(6'b111100));

    // Start held high: back-to-back conversions, one idle cycle between
    @(negedge clk);
    c = cyc;
    bin_in = 20'd5; start = 1'b1;
    push_exp(24'h000005, 6'b111110, 1'b0, c + 1 + LAT);
    push_exp(24'h000005, 6'b111110, 1'b0, c + 1 + LAT + 22);
    wait_cyc(c + LAT);
    check("b2b_busy_before", 64'(busy), 64'(1));
    wait_cyc(c + LAT + 1);
    check("b2b_busy_gap", 64'(busy), 64'(0));
    wait_cyc(c + LAT + 2);
    check("b2b_busy_again", 64'(busy), 64'(1));
    start = 1'b0;
    wait_cyc(c + 1 + LAT + 22);
    @(negedge clk);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    c = cyc;
    bin_in = 20'd12345; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'(0));
    m = model(54321);
    run(20'd54321, m.bcd, m.blank, m.ovf);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
